// File: rtl/bitplane_trigger_scheduler.sv
// Camera trigger scheduler locked to the projector bitplane stream.
// Optional define BITPLANE_SCHED_OVERRUN_EN enables the sticky overrun flag.
module bitplane_trigger_scheduler #(
    parameter int N_BIT_PLANES = 12,
    parameter int FRAME_W      = 16,
    parameter int HOLDOFF      = 1200
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [N_BIT_PLANES-1:0] cfg_mask,
    input  logic [FRAME_W-1:0]      cfg_frames,
    input  logic                    abort,
    input  logic                    vsync_p,
    input  logic                    bitplane_p,
    output logic                    trig,
    output logic                    armed,
    output logic                    done,
    output logic [FRAME_W-1:0]      frame_cnt,
    output logic                    overrun
);
    localparam int PW = $clog2(N_BIT_PLANES + 1);
    localparam int HW = $clog2(HOLDOFF + 1);
    localparam logic [PW-1:0] PLANE_END = PW'(N_BIT_PLANES);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VSYNC, RUN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [N_BIT_PLANES-1:0] mask_q;
    logic [FRAME_W-1:0]      frames_q;
    logic [FRAME_W-1:0]      frame_cnt_nxt;
    logic [PW-1:0]           plane_idx, plane_idx_nxt, cur_idx;
    logic [HW-1:0]           holdoff;
    logic                    accept, bp_take, plane_hit, fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt     = state;
        plane_idx_nxt = plane_idx;
        frame_cnt_nxt = frame_cnt;
        cur_idx       = plane_idx;
        accept        = 1'b0;
        bp_take       = 1'b0;
        case (state)
            IDLE: begin
                // abort beats a handshake presented in the same cycle
                if (cfg_ready && cfg_valid && !abort) begin
                    accept        = 1'b1;
                    frame_cnt_nxt = '0;
                    plane_idx_nxt = '0;
                    state_nxt     = WAIT_VSYNC;
                end
            end
            WAIT_VSYNC: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (vsync_p) begin
                    plane_idx_nxt = '0;
                    state_nxt     = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    bp_take = bitplane_p;
                    // vsync first: a coincident bitplane is plane 0 of the new frame, or dropped at run end
                    if (vsync_p) begin
                        frame_cnt_nxt = frame_cnt + FRAME_W'(1);
                        if (frames_q != '0 && frame_cnt_nxt == frames_q) begin
                            state_nxt = DONE;
                            bp_take   = 1'b0;
                        end else begin
                            cur_idx = '0;
                        end
                    end
                    plane_idx_nxt = cur_idx;
                    if (bp_take && cur_idx != PLANE_END) plane_idx_nxt = cur_idx + PW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign plane_hit = bp_take && (cur_idx != PLANE_END) && mask_q[cur_idx];
    assign fire      = plane_hit && (holdoff == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q    <= '0;
            frames_q  <= '0;
            plane_idx <= '0;
            frame_cnt <= '0;
            holdoff   <= '0;
            trig      <= 1'b0;
            armed     <= 1'b0;
            done      <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (accept) begin
                mask_q   <= cfg_mask;
                frames_q <= cfg_frames;
            end
            plane_idx <= plane_idx_nxt;
            frame_cnt <= frame_cnt_nxt;
            trig      <= fire;
            armed     <= (state_nxt == WAIT_VSYNC) || (state_nxt == RUN);
            done      <= (state_nxt == DONE);
            cfg_ready <= (state_nxt == IDLE);
            // holdoff runs regardless of state and survives abort
            if (fire)                holdoff <= HOLD_LOAD;
            else if (holdoff != '0) holdoff <= holdoff - HW'(1);
        end
    end

`ifdef BITPLANE_SCHED_OVERRUN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                            overrun <= 1'b0;
        else if (accept)                     overrun <= 1'b0;
        else if (plane_hit && holdoff != '0) overrun <= 1'b1;
    end
`else
    assign overrun = 1'b0;
`endif

endmodule
